// File: rtl/trena_pkg.sv
// Shared state encodings and character-select constants for the trena_uc controller.
package trena_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        AGUARDA_MEDIDA = 4'd2,
        TRANSMITE      = 4'd3,
        AGUARDA_TX     = 4'd4,
        PROXIMO        = 4'd5,
        FINAL          = 4'd6,
        ERRO           = 4'd7
    } estado_t;

    localparam logic [1:0] SEL_CENTENA   = 2'd2;
    localparam logic [1:0] SEL_DEZENA    = 2'd1;
    localparam logic [1:0] SEL_UNIDADE   = 2'd0;
    localparam logic [1:0] SEL_SEPARADOR = 2'd3;

    localparam logic [1:0] ULTIMO_INDICE = 2'd3;

    // Frame order: hundreds, tens, units, then the '#' separator.
    function automatic logic [1:0] indice_para_seletor(input logic [1:0] indice);
        logic [1:0] sel;
        sel = SEL_CENTENA;
        case (indice)
            2'd0:    sel = SEL_CENTENA;
            2'd1:    sel = SEL_DEZENA;
            2'd2:    sel = SEL_UNIDADE;
            default: sel = SEL_SEPARADOR;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/trena_timeout_counter.sv
// Cycle counter for the measurement wait; fim flags the last allowed cycle
// (TIMEOUT_CYCLES-1) while enabled.
module trena_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !fim) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fim = enable && (count_q == CNT_FIM);

endmodule

// File: rtl/trena_uc.sv
// trena_uc: sequences one HC-SR04 measurement and a 4-character serial frame.
// Define TRENA_TIMEOUT_EN to abort a stalled measurement after TIMEOUT_CYCLES.
module trena_uc
    import trena_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mensurar,
    input  logic       pronto_medida,
    input  logic       pronto_transmissao,
    output logic       medir,
    output logic       partida,
    output logic [1:0] seletor,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    estado_t    estado_q, estado_d;
    logic [1:0] indice_q, indice_d;
    logic       timeout_fim;

`ifdef TRENA_TIMEOUT_EN
    trena_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_q != AGUARDA_MEDIDA),
        .enable (estado_q == AGUARDA_MEDIDA),
        .fim    (timeout_fim)
    );

    assign erro = (estado_q == ERRO);
`else
    // No counter in this build: the measurement wait never expires.
    assign timeout_fim = 1'b0 && (TIMEOUT_CYCLES != 0);
    assign erro        = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        case (estado_q)
            INICIAL: begin
                if (mensurar) estado_d = PREPARA;
            end
            PREPARA: begin
                indice_d = '0;
                estado_d = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                // A valid measurement wins over a timeout in the same cycle.
                if (pronto_medida)    estado_d = TRANSMITE;
                else if (timeout_fim) estado_d = ERRO;
            end
            TRANSMITE: begin
                estado_d = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (pronto_transmissao) estado_d = PROXIMO;
            end
            PROXIMO: begin
                if (indice_q == ULTIMO_INDICE) begin
                    estado_d = FINAL;
                end else begin
                    indice_d = indice_q + 2'd1;
                    estado_d = TRANSMITE;
                end
            end
            FINAL:   estado_d = INICIAL;
            ERRO:    estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            indice_q <= '0;
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
        end
    end

    assign medir     = (estado_q == PREPARA);
    assign partida   = (estado_q == TRANSMITE);
    assign pronto    = (estado_q == FINAL);
    assign seletor   = indice_para_seletor(indice_q);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_trena_uc.sv
// Scoreboard bench for trena_uc: a frame-timeline model predicts every output pulse
// (kind, cycle, character select) and a monitor matches what the DUT presents.
module tb_trena_uc;

    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       mensurar;
    logic       pronto_medida;
    logic       pronto_transmissao;
    logic       medir;
    logic       partida;
    logic [1:0] seletor;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    trena_uc #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mensurar           (mensurar),
        .pronto_medida      (pronto_medida),
        .pronto_transmissao (pronto_transmissao),
        .medir              (medir),
        .partida            (partida),
        .seletor            (seletor),
        .pronto             (pronto),
        .erro               (erro),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    typedef enum int {EV_MEDIR = 0, EV_PARTIDA = 1, EV_PRONTO = 2, EV_ERRO = 3} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [1:0] sel;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [1:0] ordem [4] = '{2'd2, 2'd1, 2'd0, 2'd3};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic match(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'(k), -1);
            return;
        end
        e = exp_q.pop_front();
        check("pulse_kind", int'(k), int'(e.kind));
        check("pulse_cycle", cyc, e.cyc);
        if (k == EV_PARTIDA) check("partida_seletor", int'(seletor), int'(e.sel));
    endtask

    // Monitor: every pulse the DUT presents must be the next predicted one.
    always @(negedge clock) begin
        if (reset) begin
            if (medir)   match(EV_MEDIR);
            if (partida) match(EV_PARTIDA);
            if (pronto)  match(EV_PRONTO);
            if (erro)    match(EV_ERRO);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [1:0] s, input int c);
        ev_t e;
        e.kind = k;
        e.sel  = s;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    function automatic logic nb(input bit en);
        return en ? ($urandom_range(0, 3) == 0) : 1'b0;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            mensurar           = 1'b0;
            pronto_medida      = nb(1'b1);
            pronto_transmissao = nb(1'b1);
        end
        pronto_medida      = 1'b0;
        pronto_transmissao = 1'b0;
    endtask

    // One frame starting with the DUT idle in the current cycle. dm: cycles from the
    // request to the pronto_medida pulse (>=2); dtx: cycles from each partida to its
    // pronto_transmissao (>=1). abort_char selects the character whose transmit wait
    // is cut short by reset (-1 for none).
    task automatic run_frame(input int dm, input int dtx, input bit hold, input bit noise,
                             input int abort_char);
        int c0, tp, tx;
        c0 = cyc;
        mensurar           = 1'b1;
        pronto_medida      = nb(noise);
        pronto_transmissao = nb(noise);
        expect_ev(EV_MEDIR, 2'd0, c0 + 1);
        while (cyc < c0 + dm) begin
            tick();
            mensurar           = hold | nb(noise);
            pronto_medida      = 1'b0;
            pronto_transmissao = nb(noise);
        end
        pronto_medida = 1'b1;
        tp = cyc + 1;
        expect_ev(EV_PARTIDA, ordem[0], tp);
        for (int i = 0; i < 4; i++) begin
            while (cyc < tp + dtx) begin
                tick();
                mensurar           = hold | nb(noise);
                pronto_medida      = nb(noise);
                pronto_transmissao = 1'b0;
                if (i == abort_char && cyc == tp + 1) begin
                    check("pre_reset_estado", int'(db_estado), 4);
                    #1 reset = 1'b0;
                    #1;
                    check("rst_db_estado", int'(db_estado), 0);
                    check("rst_seletor", int'(seletor), 2);
                    check("rst_pulses", int'({medir, partida, pronto, erro}), 0);
                    mensurar           = 1'b0;
                    pronto_medida      = 1'b0;
                    pronto_transmissao = 1'b0;
                    tick();
                    tick();
                    reset = 1'b1;
                    tick();
                    check("post_rst_estado", int'(db_estado), 0);
                    return;
                end
            end
            check("seletor_hold", int'(seletor), int'(ordem[i]));
            pronto_transmissao = 1'b1;
            tx = cyc;
            if (i < 3) begin
                tp = tx + 2;
                expect_ev(EV_PARTIDA, ordem[i+1], tp);
            end else begin
                expect_ev(EV_PRONTO, 2'd0, tx + 2);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            mensurar           = hold;
            pronto_medida      = 1'b0;
            pronto_transmissao = 1'b0;
        end
        check("frame_end_inicial", int'(db_estado), 0);
    endtask

`ifdef TRENA_TIMEOUT_EN
    task automatic run_timeout();
        int c0;
        c0 = cyc;
        mensurar = 1'b1;
        expect_ev(EV_MEDIR, 2'd0, c0 + 1);
        expect_ev(EV_ERRO, 2'd0, c0 + 2 + TIMEOUT);
        while (cyc < c0 + 3 + TIMEOUT) begin
            tick();
            mensurar           = 1'b0;
            pronto_medida      = 1'b0;
            pronto_transmissao = nb(1'b1);
        end
        pronto_transmissao = 1'b0;
        check("timeout_back_inicial", int'(db_estado), 0);
    endtask
`endif

    function automatic int rand_dm();
`ifdef TRENA_TIMEOUT_EN
        return int'($urandom_range(2, TIMEOUT + 1));
`else
        return int'($urandom_range(2, 40));
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        mensurar           = 1'b0;
        pronto_medida      = 1'b0;
        pronto_transmissao = 1'b0;
        #1;
        check("reset_db_estado", int'(db_estado), 0);
        check("reset_seletor", int'(seletor), 2);
        check("reset_medir", int'(medir), 0);
        check("reset_partida", int'(partida), 0);
        check("reset_pronto", int'(pronto), 0);
        check("reset_erro", int'(erro), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        idle(4);
        check("idle_estado", int'(db_estado), 0);

        // Reference frame: measurement 10 cycles after the request, 20-cycle characters.
        run_frame(10, 20, 1'b0, 1'b0, -1);
        idle(5);

        // Request held high: second frame follows after a single idle cycle.
        run_frame(rand_dm(), int'($urandom_range(1, 6)), 1'b1, 1'b0, -1);
        run_frame(rand_dm(), int'($urandom_range(1, 6)), 1'b0, 1'b0, -1);
        idle(3);

        // Spurious requests and handshakes while busy.
        for (int f = 0; f < 3; f++) begin
            run_frame(rand_dm(), int'($urandom_range(1, 12)), 1'b0, 1'b1, -1);
            idle(int'($urandom_range(1, 6)));
        end

        // Reset while waiting on the second character, then a clean frame.
        run_frame(rand_dm(), int'($urandom_range(2, 8)), 1'b0, 1'b1, 1);
        idle(2);
        run_frame(rand_dm(), int'($urandom_range(1, 8)), 1'b0, 1'b1, -1);
        idle(2);

`ifdef TRENA_TIMEOUT_EN
        run_timeout();
        idle(2);
        run_frame(TIMEOUT + 1, 3, 1'b0, 1'b1, -1);
        idle(2);
`else
        run_frame(60, 2, 1'b0, 1'b1, -1);
        idle(2);
`endif

        for (int f = 0; f < 4; f++) begin
            run_frame(rand_dm(), int'($urandom_range(1, 15)), f[0], 1'b1, -1);
            if (!f[0]) idle(int'($urandom_range(0, 4)));
        end
        run_frame(rand_dm(), 1, 1'b0, 1'b0, -1);
        idle(10);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
